// File: rtl/datapath_nreg_pkg.sv
// Shared opcode encoding and pipeline limits for the arithmetic/logic datapath.
package datapath_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SRA = 3'b110,
        OP_SLT = 3'b111
    } opcode_t;

    localparam int MAX_PIPE_STAGES = 2;

endpackage

// File: rtl/datapath_nreg_if.sv
// Operand/result bus between operand sources, the datapath and result consumers.
interface datapath_nreg_if
    import datapath_pkg::*;
#(
    parameter int N = 16
);
    logic signed [N-1:0] A;
    logic signed [N-1:0] B;
    opcode_t             opcode;
    logic signed [N-1:0] Y;
    logic                co;

    modport master (output A, output B, output opcode, input Y, input co);
    modport slave  (input A, input B, input opcode, output Y, output co);
endinterface

// File: rtl/datapath_nreg_alu.sv
// Combinational signed ALU: add/sub with carry, bitwise logic, shifts, signed compare.
module datapath_alu
    import datapath_pkg::*;
#(
    parameter int N = 16
) (
    input  logic signed [N-1:0] a,
    input  logic signed [N-1:0] b,
    input  opcode_t             opcode,
    output logic signed [N-1:0] y,
    output logic                co
);

    function automatic logic [N:0] add_carry(input logic [N-1:0] x, input logic [N-1:0] z,
                                             input logic cin);
        return {1'b0, x} + {1'b0, z} + {{N{1'b0}}, cin};
    endfunction

    // Bit N of the widened result is the last bit shifted out (0 for a zero shift).
    function automatic logic [N:0] shl_out(input logic [N-1:0] x, input logic [3:0] amt);
        return {1'b0, x} << amt;
    endfunction

    // Bit 0 of the widened result is the last bit shifted out; beyond N it is the sign.
    function automatic logic [N:0] sra_out(input logic signed [N-1:0] x, input logic [3:0] amt);
        logic signed [N:0] ext;
        ext = {x, 1'b0};
        return ext >>> amt;
    endfunction

    logic       is_sub;
    logic [N:0] sum;
    logic [N:0] shl;
    logic [N:0] sra;

    assign is_sub = (opcode == OP_SUB);
    assign sum    = add_carry(a, is_sub ? ~b : b, is_sub);
    assign shl    = shl_out(a, b[3:0]);
    assign sra    = sra_out(a, b[3:0]);

    always_comb begin
        y  = '0;
        co = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB: {co, y} = sum;
            OP_AND:         y = a & b;
            OP_OR:          y = a | b;
            OP_XOR:         y = a ^ b;
            OP_SHL:         {co, y} = shl;
            OP_SRA: begin
                y  = sra[N:1];
                co = sra[0];
            end
            OP_SLT:         y = (a < b) ? {{(N-1){1'b0}}, 1'b1} : '0;
            default: begin
                y  = '0;
                co = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/datapath_nreg.sv
// Signed ALU datapath with 0, 1 or 2 register stages wrapped around one shared ALU.
module datapath_nreg
    import datapath_pkg::*;
#(
    parameter int N           = 16,
    parameter int PIPE_STAGES = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    datapath_nreg_if.slave  bus
);

    if (PIPE_STAGES < 0 || PIPE_STAGES > MAX_PIPE_STAGES) begin : g_bad_stages
        $error("datapath_nreg: PIPE_STAGES must be 0, 1 or 2");
    end

    logic signed [N-1:0] alu_a;
    logic signed [N-1:0] alu_b;
    opcode_t             alu_op;
    logic signed [N-1:0] alu_y;
    logic                alu_co;

    datapath_alu #(.N(N)) u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .opcode (alu_op),
        .y      (alu_y),
        .co     (alu_co)
    );

    // Stage p0: optional operand register; a zeroed stage reads as ADD 0+0.
    if (PIPE_STAGES == 2) begin : g_in_reg
        logic signed [N-1:0] a_p0;
        logic signed [N-1:0] b_p0;
        opcode_t             op_p0;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a_p0  <= '0;
                b_p0  <= '0;
                op_p0 <= OP_ADD;
            end else begin
                a_p0  <= bus.A;
                b_p0  <= bus.B;
                op_p0 <= bus.opcode;
            end
        end

        assign alu_a  = a_p0;
        assign alu_b  = b_p0;
        assign alu_op = op_p0;
    end else begin : g_in_comb
        assign alu_a  = bus.A;
        assign alu_b  = bus.B;
        assign alu_op = bus.opcode;
    end

    // Stage p1: optional result register.
    if (PIPE_STAGES >= 1) begin : g_out_reg
        logic signed [N-1:0] y_p1;
        logic                co_p1;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                y_p1  <= '0;
                co_p1 <= 1'b0;
            end else begin
                y_p1  <= alu_y;
                co_p1 <= alu_co;
            end
        end

        assign bus.Y  = y_p1;
        assign bus.co = co_p1;
    end else begin : g_out_comb
        // Fully combinational build: clock and reset are intentionally left unused.
        logic unused_clk_rst;
        assign unused_clk_rst = &{1'b0, clk, rst_n};

        assign bus.Y  = alu_y;
        assign bus.co = alu_co;
    end

endmodule

// File: tb/tb_datapath_nreg.sv
// Drives the same operand stream into 0/1/2-stage builds and checks each against a reference.
module tb_datapath_nreg;
    import datapath_pkg::*;

    localparam int N = 16;

    typedef struct {
        string       nm;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  op;
        logic [15:0] y;
        logic        co;
    } vec_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] a_d   = '0;
    logic [15:0] b_d   = '0;
    logic [2:0]  op_d  = 3'd0;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          sidx     = 0;
    logic [16:0] hist [0:2047];
    vec_t        tbl  [0:16];

    datapath_nreg_if #(.N(N)) if0 ();
    datapath_nreg_if #(.N(N)) if1 ();
    datapath_nreg_if #(.N(N)) if2 ();

    assign if0.A = a_d;  assign if0.B = b_d;  assign if0.opcode = opcode_t'(op_d);
    assign if1.A = a_d;  assign if1.B = b_d;  assign if1.opcode = opcode_t'(op_d);
    assign if2.A = a_d;  assign if2.B = b_d;  assign if2.opcode = opcode_t'(op_d);

    datapath_nreg #(.N(N), .PIPE_STAGES(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    datapath_nreg #(.N(N), .PIPE_STAGES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    datapath_nreg #(.N(N), .PIPE_STAGES(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    always #5 clk = ~clk;

    // Reference: opcode rules evaluated with plain integer arithmetic.
    function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic [2:0] op);
        int unsigned ua  = a;
        int unsigned ub  = b;
        int          sa  = $signed(a);
        int          sb  = $signed(b);
        int          amt = int'(b[3:0]);
        int          r   = 0;
        logic        c   = 1'b0;
        case (op)
            3'd0: begin r = int'(ua + ub); c = (ua + ub) > 32'd65535; end
            3'd1: begin r = sa - sb;       c = (ua >= ub); end
            3'd2: r = int'(ua & ub);
            3'd3: r = int'(ua | ub);
            3'd4: r = int'(ua ^ ub);
            3'd5: begin
                r = int'(ua << amt);
                c = (amt != 0) && (((ua >> (16 - amt)) & 1) != 0);
            end
            3'd6: begin
                r = sa >>> amt;
                c = (amt != 0) && (((sa >>> (amt - 1)) & 1) != 0);
            end
            default: r = (sa < sb) ? 1 : 0;
        endcase
        return {c, r[15:0]};
    endfunction

    task automatic chk(input string nm, input logic [16:0] got, input logic [16:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got co=%b Y=%h, expected co=%b Y=%h",
                     nm, got[16], got[15:0], exp[16], exp[15:0]);
        end
    endtask

    // Called at a falling edge: checks pipelined outputs against history, applies a vector.
    task automatic step(input string nm, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] op, input logic [16:0] exp);
        if (sidx == 0) chk($sformatf("post_reset_p1 %s", nm), {if1.co, if1.Y}, 17'd0);
        if (sidx >= 1) chk($sformatf("pipe1 step%0d", sidx), {if1.co, if1.Y}, hist[sidx-1]);
        if (sidx <= 1) chk($sformatf("zeroed_stage_p2 step%0d", sidx), {if2.co, if2.Y}, 17'd0);
        else           chk($sformatf("pipe2 step%0d", sidx), {if2.co, if2.Y}, hist[sidx-2]);
        a_d  = a;
        b_d  = b;
        op_d = op;
        hist[sidx] = exp;
        sidx++;
        #1;
        chk($sformatf("comb %s", nm), {if0.co, if0.Y}, exp);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        a_d   = 16'h1234;
        b_d   = 16'h4321;
        op_d  = 3'd1;
        #1;
        chk("reset_p1", {if1.co, if1.Y}, 17'd0);
        chk("reset_p2", {if2.co, if2.Y}, 17'd0);
        @(negedge clk);
        chk("reset_hold_p1", {if1.co, if1.Y}, 17'd0);
        chk("reset_hold_p2", {if2.co, if2.Y}, 17'd0);
        rst_n = 1'b1;
        sidx  = 0;
    endtask

    task automatic mid_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_clear_p1", {if1.co, if1.Y}, 17'd0);
        chk("async_clear_p2", {if2.co, if2.Y}, 17'd0);
        @(posedge clk);
        #1;
        chk("clear_held_p1", {if1.co, if1.Y}, 17'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sidx  = 0;
    endtask

    initial begin
        tbl[0]  = '{"add_carry",  16'hFFFF, 16'h0001, 3'd0, 16'h0000, 1'b1};
        tbl[1]  = '{"add_ovf",    16'h7FFF, 16'h0001, 3'd0, 16'h8000, 1'b0};
        tbl[2]  = '{"sub_pos",    16'h0005, 16'h0003, 3'd1, 16'h0002, 1'b1};
        tbl[3]  = '{"sub_borrow", 16'h0003, 16'h0005, 3'd1, 16'hFFFE, 1'b0};
        tbl[4]  = '{"sub_equal",  16'h0007, 16'h0007, 3'd1, 16'h0000, 1'b1};
        tbl[5]  = '{"and",        16'hF0F0, 16'h0FF0, 3'd2, 16'h00F0, 1'b0};
        tbl[6]  = '{"or",         16'hF0F0, 16'h0FF0, 3'd3, 16'hFFF0, 1'b0};
        tbl[7]  = '{"xor",        16'hF0F0, 16'h0FF0, 3'd4, 16'hFF00, 1'b0};
        tbl[8]  = '{"sra4",       16'h8000, 16'h0004, 3'd6, 16'hF800, 1'b0};
        tbl[9]  = '{"sra1_hiB",   16'h8001, 16'hFFF1, 3'd6, 16'hC000, 1'b1};
        tbl[10] = '{"sra15",      16'h8000, 16'h000F, 3'd6, 16'hFFFF, 1'b0};
        tbl[11] = '{"shl1",       16'h8001, 16'h0001, 3'd5, 16'h0002, 1'b1};
        tbl[12] = '{"shl0_hiB",   16'h1234, 16'h0010, 3'd5, 16'h1234, 1'b0};
        tbl[13] = '{"shl15",      16'h0003, 16'h000F, 3'd5, 16'h8000, 1'b1};
        tbl[14] = '{"slt_true",   16'hFFFD, 16'h0002, 3'd7, 16'h0001, 1'b0};
        tbl[15] = '{"slt_false",  16'h0002, 16'hFFFD, 3'd7, 16'h0000, 1'b0};
        tbl[16] = '{"slt_equal",  16'h8000, 16'h8000, 3'd7, 16'h0000, 1'b0};

        do_reset();
        for (int i = 0; i <= 16; i++)
            step(tbl[i].nm, tbl[i].a, tbl[i].b, tbl[i].op, {tbl[i].co, tbl[i].y});

        // Two-stage latency: ADD then SUB on consecutive edges, 30 then 42 two edges later.
        a_d = 16'd10; b_d = 16'd20; op_d = 3'd0;
        @(posedge clk);
        @(negedge clk);
        chk("lat_prior_hold_p2", {if2.co, if2.Y}, hist[sidx-1]);
        a_d = 16'd50; b_d = 16'd8; op_d = 3'd1;
        @(posedge clk);
        #1;
        chk("lat_add_p2", {if2.co, if2.Y}, {1'b0, 16'd30});
        @(negedge clk);
        chk("lat_add_hold_p2", {if2.co, if2.Y}, {1'b0, 16'd30});
        a_d = 16'd0; b_d = 16'd0; op_d = 3'd2;
        @(posedge clk);
        #1;
        chk("lat_sub_p2", {if2.co, if2.Y}, {1'b1, 16'd42});

        do_reset();
        for (int i = 0; i < 1000; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            logic [2:0]  ro;
            ra = 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
            ro = 3'($urandom_range(0, 7));
            if (i == 500) mid_reset();
            step("rand", ra, rb, ro, model(ra, rb, ro));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/datapath_nreg.md
Name: datapath_nreg

Overview:
Parameterised signed N-bit arithmetic/logic datapath with a 3-bit opcode.
- Computes Y and a carry flag co from two signed operands.
- Has a configurable number of pipeline register stages: 0, 1 or 2.
- Sits between operand sources and result consumers in the arithmetic path of the accelerator.
- One clock domain with asynchronous active-low reset.

Parameters:
N, 16, operand/result width in bits (N >= 4)
PIPE_STAGES, 0, number of pipeline register stages (legal 0, 1, 2; other values are a compile-time error)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
A  input  N  signed operand A
B  input  N  signed operand B
opcode  input  3  operation select
Y  output  N  signed result
co  output  1  carry/flag output

Behaviour:
Interface:
- One clock (clk).
- Reset rst_n is asynchronous and active-low.

Opcode map (co = 0 unless stated):
- 000 ADD: {co,Y} = A + B (unsigned N+1-bit sum); co = carry out of bit N-1.
- 001 SUB: {co,Y} = A + ~B + 1; co = 1 means no borrow (A >= B unsigned).
- 010 AND: Y = A & B.
- 011 OR: Y = A | B.
- 100 XOR: Y = A ^ B.
- 101 SHL: Y = A << B[3:0] (logical); co = last bit shifted out (0 if shift amount is 0).
- 110 SRA: Y = A >>> B[3:0] (arithmetic, sign-filled); co = last bit shifted out (0 if shift amount is 0).
- 111 SLT: Y = (A < B signed) ? 1 : 0, zero-extended; co = 0.

Widths:
- Y wraps modulo 2^N; no saturation.
- Signed overflow is not flagged.
- Shift amount uses only B[3:0]; upper B bits are ignored.

Pipelining:
- PIPE_STAGES=0: purely combinational; Y/co follow the inputs in the same cycle; rst_n has no effect.
- PIPE_STAGES=1: A, B and opcode are combined combinationally; the {Y,co} result register is updated every rising edge. Latency is 1 cycle.
- PIPE_STAGES=2: input register stage on A, B, opcode, then the ALU, then the output register stage. Latency is 2 cycles.
- Throughput is one operation per cycle. No handshake and no stall; every edge advances every stage.

Reset:
- While rst_n=0, all pipeline registers are 0, so Y=0 and co=0 for PIPE_STAGES>=1.
- Deassertion takes effect at the next rising edge; in-flight operations are discarded.
- Assertion mid-operation immediately clears the outputs.
- After reset release with PIPE_STAGES=2, the first cycle's output is the ALU result of the zeroed input stage: ADD 0+0, so Y=0, co=0.

Decomposition:
- Shared package datapath_pkg holds:
  - the opcode enum (OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SRA, OP_SLT) as 3-bit typedef opcode_t;
  - the constant MAX_PIPE_STAGES = 2.
- One natural sub-module, datapath_alu: the combinational ALU (A, B, opcode -> Y, co), parameterised by N.
- The top level instantiates datapath_alu and generates the 0/1/2 register stages around it.

Test Plan:
- PIPE_STAGES=0, ADD: A=16'hFFFF, B=16'h0001 -> Y=16'h0000, co=1. ADD A=16'h7FFF, B=16'h0001 -> Y=16'h8000, co=0.
- PIPE_STAGES=0, SUB: A=5, B=3 -> Y=2, co=1. SUB A=3, B=5 -> Y=16'hFFFE, co=0.
- Logic and shifts:
  - AND/OR/XOR with A=16'hF0F0, B=16'h0FF0 -> 16'h00F0 / 16'hFFF0 / 16'hFF00.
  - SRA A=16'h8000, B=4 -> Y=16'hF800, co=0.
  - SHL A=16'h8001, B=1 -> Y=16'h0002, co=1.
  - SLT A=-3, B=2 -> Y=1.
- PIPE_STAGES=2 latency:
  - Apply ADD 10+20 at edge k, then SUB 50-8 at edge k+1.
  - Y=30 is visible after edge k+2; Y=42 after edge k+3.
  - Outputs hold the prior value in between.
- PIPE_STAGES=1, reset mid-stream:
  - Streaming random ops, assert rst_n=0 asynchronously between edges -> Y=0, co=0 immediately.
  - Release rst_n -> the first valid result appears 1 cycle after the first edge with rst_n=1.
- Randomised check for each PIPE_STAGES value: 1000 random A/B/opcode vectors compared to a reference model delayed by PIPE_STAGES cycles -> zero mismatches.
